// File: rtl/bpu_pkg.sv
// bpu_pkg: state encoding, table entry types and counter helper for the branch predictor
package bpu_pkg;
    localparam int BPU_IDX_W = 6;
    localparam int BPU_TAG_W = 8;
    typedef enum logic [1:0] {INIT, RUN, REDIRECT} bpu_state_e;
    typedef logic [1:0] bht_ctr_t;
    localparam bht_ctr_t SNT = 2'd0;
    localparam bht_ctr_t WNT = 2'd1;
    localparam bht_ctr_t WT = 2'd2;
    localparam bht_ctr_t ST = 2'd3;
    typedef struct packed {
        logic valid;
        logic [BPU_TAG_W-1:0] tag;
        logic [31:0] target;
    } btb_entry_t;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pred_target;
        logic wrong;
        logic live;
    } inflight_t;
    function automatic bht_ctr_t next_ctr(bht_ctr_t ctr, logic taken);
        return taken ? (ctr == ST ? ST : ctr + 2'd1) : (ctr == SNT ? SNT : ctr - 2'd1);
    endfunction
endpackage

// File: rtl/bpu_predictor_if.sv
// bpu_predictor_if: fetch/prediction, ground-truth feedback and redirect signals of the predictor
// With BPU_PERF_CNT_EN defined the interface also carries the performance counters.
interface bpu_predictor_if;
    logic stall;
    logic [31:0] bpu_fetch_pc;
    logic bpu_valid;
    logic pred_taken;
    logic [31:0] pred_target;
    logic actual_is_branch;
    logic actual_taken;
    logic [31:0] actual_target_pc;
    logic feedback_valid;
    logic flush;
    logic [31:0] redirect_pc;
`ifdef BPU_PERF_CNT_EN
    logic [31:0] perf_issues, perf_branches, perf_mispredicts;
    modport master(input stall, actual_is_branch, actual_taken, actual_target_pc, feedback_valid,
                   output bpu_fetch_pc, bpu_valid, pred_taken, pred_target, flush, redirect_pc,
                   perf_issues, perf_branches, perf_mispredicts);
    modport slave(output stall, actual_is_branch, actual_taken, actual_target_pc, feedback_valid,
                  input bpu_fetch_pc, bpu_valid, pred_taken, pred_target, flush, redirect_pc,
                  perf_issues, perf_branches, perf_mispredicts);
`else
    modport master(input stall, actual_is_branch, actual_taken, actual_target_pc, feedback_valid,
                   output bpu_fetch_pc, bpu_valid, pred_taken, pred_target, flush, redirect_pc);
    modport slave(output stall, actual_is_branch, actual_taken, actual_target_pc, feedback_valid,
                  input bpu_fetch_pc, bpu_valid, pred_taken, pred_target, flush, redirect_pc);
`endif
endinterface

// File: rtl/bpu_btb.sv
// bpu_btb: direct-mapped BTB and bimodal BHT storage, async read, sync training write, init clear
module bpu_btb import bpu_pkg::*; #(
    parameter int IDX_W = BPU_IDX_W
) (
    input  logic clk,
    input  logic [IDX_W-1:0] rd_idx,
    output bht_ctr_t rd_ctr,
    output btb_entry_t rd_entry,
    input  logic wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic wr_taken,
    input  logic [BPU_TAG_W-1:0] wr_tag,
    input  logic [31:0] wr_target,
    input  logic clr_en,
    input  logic [IDX_W-1:0] clr_idx
);
    bht_ctr_t bht [2**IDX_W];
    btb_entry_t btb [2**IDX_W];
    assign rd_ctr = bht[rd_idx];
    assign rd_entry = btb[rd_idx];
    // clear one entry per cycle during init, otherwise apply at most one training update
    always_ff @(posedge clk) begin
        if (clr_en) begin
            bht[clr_idx] <= WNT;
            btb[clr_idx] <= '0;
        end else if (wr_en) begin
            bht[wr_idx] <= next_ctr(bht[wr_idx], wr_taken);
            if (wr_taken) btb[wr_idx] <= btb_entry_t'{valid: 1'b1, tag: wr_tag, target: wr_target};
        end
    end
endmodule

// File: rtl/bpu_predictor.sv
// bpu_predictor: fetch PC generator with BTB/BHT prediction, training and mispredict redirect
// Optional macro BPU_PERF_CNT_EN adds wrapping issue/branch/mispredict counters.
module bpu_predictor import bpu_pkg::*; #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int IDX_W = BPU_IDX_W,
    parameter int TAG_W = BPU_TAG_W
) (
    input logic clk,
    input logic rst,
    bpu_predictor_if.master b
);
    bpu_state_e state, state_nx;
    logic [IDX_W-1:0] init_idx;
    logic [31:0] pc, actual_next, redirect_q;
    inflight_t infl;
    bht_ctr_t ctr;
    btb_entry_t entry;
    logic hit, taken, issue, resolve, mispredict, train;

    bpu_btb #(.IDX_W(IDX_W)) u_btb (
        .clk(clk),
        .rd_idx(pc[IDX_W+1:2]),
        .rd_ctr(ctr),
        .rd_entry(entry),
        .wr_en(train),
        .wr_idx(infl.pc[IDX_W+1:2]),
        .wr_taken(b.actual_taken),
        .wr_tag(infl.pc[IDX_W+TAG_W+1:IDX_W+2]),
        .wr_target(b.actual_target_pc),
        .clr_en(state == INIT),
        .clr_idx(init_idx)
    );

    assign hit = entry.valid && entry.tag == pc[IDX_W+TAG_W+1:IDX_W+2];
    assign taken = hit && ctr[1];
    assign issue = state == RUN && !b.stall;
    assign b.bpu_fetch_pc = pc;
    assign b.bpu_valid = issue;
    assign b.pred_taken = state == RUN && taken;
    assign b.pred_target = state != RUN ? '0 : taken ? entry.target : pc + 32'd4;
    assign b.flush = state == REDIRECT;
    assign b.redirect_pc = redirect_q;
    // feedback only counts for a live, right-path issue made in the previous cycle
    assign resolve = state == RUN && infl.live && !infl.wrong && b.feedback_valid;
    assign actual_next = b.actual_is_branch && b.actual_taken ? b.actual_target_pc : infl.pc + 32'd4;
    assign mispredict = resolve && actual_next != infl.pred_target;
    assign train = resolve && b.actual_is_branch;

    // state register; reset restarts the table sweep
    always_ff @(posedge clk) state <= rst ? INIT : state_nx;

    // sweep every table entry once, then run; each mispredict costs one redirect bubble
    always_comb begin
        state_nx = state == INIT ? (&init_idx ? RUN : INIT) : (state == RUN && mispredict ? REDIRECT : RUN);
    end

    // fetch PC, in-flight record, redirect target and sweep index; redirect beats stall
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
            infl <= '0;
            redirect_q <= '0;
            init_idx <= '0;
        end else begin
            init_idx <= state == INIT ? init_idx + IDX_W'(1) : '0;
            pc <= mispredict ? actual_next : issue ? b.pred_target : pc;
            infl <= issue ? inflight_t'{pc: pc, pred_target: b.pred_target, wrong: mispredict, live: 1'b1} : '0;
            if (mispredict) redirect_q <= actual_next;
        end
    end

`ifdef BPU_PERF_CNT_EN
    logic [31:0] n_issue, n_branch, n_mispredict;
    assign b.perf_issues = n_issue;
    assign b.perf_branches = n_branch;
    assign b.perf_mispredicts = n_mispredict;
    // count issues, trained branches and mispredicts, wrapping at 32 bits
    always_ff @(posedge clk) begin
        if (rst) begin
            n_issue <= '0;
            n_branch <= '0;
            n_mispredict <= '0;
        end else begin
            n_issue <= n_issue + 32'(issue);
            n_branch <= n_branch + 32'(train);
            n_mispredict <= n_mispredict + 32'(mispredict);
        end
    end
`endif
endmodule

// File: tb/tb_bpu_predictor.sv
// tb_bpu_predictor: directed and random stimulus for bpu_predictor against a table-level reference model
module tb_bpu_predictor;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    bpu_predictor_if bif();
    bpu_predictor dut(.clk(clk), .rst(rst), .b(bif));

    int errs = 0;
    int checks = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // reference model: tables as plain arrays, pipeline as "previous issue" bookkeeping
    bit m_known = 0;
    int init_left = 0;
    bit m_redir = 0;
    logic [31:0] m_pc = 0, m_redir_pc = 0;
    bit prev_live = 0, prev_wrong = 0;
    logic [31:0] prev_pc = 0, prev_tgt = 0;
    bit e_pt;
    logic [31:0] e_tgt;
    int m_ctr [64];
    bit m_v [64];
    logic [7:0] m_tag [64];
    logic [31:0] m_tgt [64];
    logic [31:0] n_issue = 0, n_br = 0, n_mis = 0;

    // compare process: expected outputs for the current cycle versus the DUT
    always @(negedge clk) begin
        bit run;
        int i;
        if (m_known) begin
            run = init_left == 0 && !m_redir;
            i = int'(m_pc[7:2]);
            e_pt = run && m_v[i] && m_tag[i] == m_pc[15:8] && m_ctr[i] >= 2;
            e_tgt = !run ? 32'd0 : e_pt ? m_tgt[i] : m_pc + 32'd4;
            chk("fetch_pc", bif.bpu_fetch_pc, m_pc);
            chk("valid", 32'(bif.bpu_valid), 32'(run && !bif.stall));
            chk("pred_taken", 32'(bif.pred_taken), 32'(e_pt));
            chk("pred_target", bif.pred_target, e_tgt);
            chk("flush", 32'(bif.flush), 32'(m_redir));
            if (m_redir) chk("redirect_pc", bif.redirect_pc, m_redir_pc);
`ifdef BPU_PERF_CNT_EN
            chk("perf_issues", bif.perf_issues, n_issue);
            chk("perf_branches", bif.perf_branches, n_br);
            chk("perf_mispredicts", bif.perf_mispredicts, n_mis);
`endif
        end
    end

    // model update at each clock edge from the inputs of the cycle just ending
    always @(posedge clk) begin
        bit res, mis;
        logic [31:0] an;
        int j;
        if (rst) begin
            m_known = 1;
            init_left = 64;
            m_redir = 0;
            m_pc = 0;
            m_redir_pc = 0;
            prev_live = 0;
            n_issue = 0;
            n_br = 0;
            n_mis = 0;
        end else if (m_known) begin
            if (init_left > 0) begin
                init_left--;
                if (init_left == 0)
                    for (int k = 0; k < 64; k++) begin
                        m_ctr[k] = 1;
                        m_v[k] = 0;
                    end
            end else if (m_redir) begin
                m_redir = 0;
                prev_live = 0;
            end else begin
                res = prev_live && !prev_wrong && bif.feedback_valid;
                an = bif.actual_is_branch && bif.actual_taken ? bif.actual_target_pc : prev_pc + 32'd4;
                mis = res && an != prev_tgt;
                if (res && bif.actual_is_branch) begin
                    j = int'(prev_pc[7:2]);
                    m_ctr[j] = bif.actual_taken ? (m_ctr[j] < 3 ? m_ctr[j] + 1 : 3) : (m_ctr[j] > 0 ? m_ctr[j] - 1 : 0);
                    if (bif.actual_taken) begin
                        m_v[j] = 1;
                        m_tag[j] = prev_pc[15:8];
                        m_tgt[j] = bif.actual_target_pc;
                    end
                    n_br++;
                end
                if (mis) n_mis++;
                if (!bif.stall) n_issue++;
                prev_live = !bif.stall;
                prev_wrong = mis;
                prev_pc = m_pc;
                prev_tgt = e_tgt;
                m_pc = mis ? an : !bif.stall ? e_tgt : m_pc;
                if (mis) begin
                    m_redir = 1;
                    m_redir_pc = an;
                end
            end
        end
    end

    task automatic drv(bit s, bit fv, bit br, bit tk, logic [31:0] tgt);
        bif.stall = s;
        bif.feedback_valid = fv;
        bif.actual_is_branch = br;
        bif.actual_taken = tk;
        bif.actual_target_pc = tgt;
        #1;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic drv_rand();
        logic [31:0] tg;
        case ($urandom_range(0, 4))
            0: tg = 32'h10;
            1: tg = 32'h40;
            2: tg = 32'h4010;
            3: tg = 32'h80;
            default: tg = 32'($urandom_range(0, 255)) << 2;
        endcase
        drv($urandom_range(0, 5) == 0, $urandom_range(0, 7) != 0, $urandom_range(0, 1) == 1,
            $urandom_range(0, 2) != 0, tg);
    endtask

    initial begin
        drv(0, 0, 0, 0, 0);
        rst = 1'b1;
        nxt();
        rst = 1'b0;
        drv(0, 1, 1, 1, 32'h80);
        chk("rst_fetch_pc", bif.bpu_fetch_pc, 32'h0);
        chk("rst_flush", 32'(bif.flush), 32'd0);
        chk("rst_pred_target", bif.pred_target, 32'h0);
        for (int i = 0; i < 64; i++) begin
            drv(0, 1, 1, 1, 32'h80);
            chk("init_valid", 32'(bif.bpu_valid), 32'd0);
            nxt();
        end
        drv(0, 0, 0, 0, 0);
        chk("run_fetch_pc", bif.bpu_fetch_pc, 32'h0);
        chk("run_valid", 32'(bif.bpu_valid), 32'd1);
        chk("run_pred_taken", 32'(bif.pred_taken), 32'd0);
        chk("run_pred_target", bif.pred_target, 32'h4);
        nxt();
        for (int k = 1; k < 4; k++) begin
            drv(0, 1, 0, 0, 0);
            chk("seq_fetch_pc", bif.bpu_fetch_pc, 32'(4 * k));
            chk("seq_flush", 32'(bif.flush), 32'd0);
            nxt();
        end
        drv(0, 1, 0, 0, 0);
        chk("br_first_pred", bif.pred_target, 32'h14);
        nxt();
        drv(0, 1, 1, 1, 32'h40);
        chk("br_wrongpath_pc", bif.bpu_fetch_pc, 32'h14);
        nxt();
        drv(0, 1, 1, 1, 32'h200);
        chk("br_flush", 32'(bif.flush), 32'd1);
        chk("br_redirect_pc", bif.redirect_pc, 32'h40);
        chk("br_redirect_valid", 32'(bif.bpu_valid), 32'd0);
        nxt();
        drv(0, 0, 0, 0, 0);
        chk("br_target_issue", bif.bpu_fetch_pc, 32'h40);
        nxt();
        drv(0, 1, 0, 0, 0);
        nxt();
        drv(0, 1, 1, 1, 32'h10);
        nxt();
        drv(0, 1, 0, 0, 0);
        chk("loop_redirect_pc", bif.redirect_pc, 32'h10);
        nxt();
        drv(0, 0, 0, 0, 0);
        chk("br_hit_taken", 32'(bif.pred_taken), 32'd1);
        chk("br_hit_target", bif.pred_target, 32'h40);
        nxt();
        drv(0, 1, 1, 1, 32'h40);
        nxt();
        drv(0, 1, 0, 0, 0);
        chk("br_hit_noflush", 32'(bif.flush), 32'd0);
        chk("loop_br_target", bif.pred_target, 32'h10);
        nxt();
        drv(0, 1, 1, 1, 32'h10);
        nxt();
        drv(1, 1, 1, 0, 0);
        chk("stall_valid", 32'(bif.bpu_valid), 32'd0);
        nxt();
        drv(1, 1, 0, 0, 0);
        chk("nt_flush", 32'(bif.flush), 32'd1);
        chk("nt_redirect_pc", bif.redirect_pc, 32'h14);
        nxt();
        drv(1, 0, 0, 0, 0);
        chk("stall_hold_pc", bif.bpu_fetch_pc, 32'h14);
        nxt();
        drv(0, 0, 0, 0, 0);
        chk("resume_valid", 32'(bif.bpu_valid), 32'd1);
        chk("wrongpath_untrained", bif.pred_target, 32'h18);
        nxt();
        drv(0, 1, 1, 1, 32'h10);
        nxt();
        drv(0, 0, 0, 0, 0);
        nxt();
        drv(0, 0, 0, 0, 0);
        chk("bht_weak_taken", 32'(bif.pred_taken), 32'd1);
        nxt();
        for (int c = 0; c < 2500; c++) begin
            if (c == 1500 || c == 1540) begin
                rst = 1'b1;
                drv_rand();
                nxt();
                rst = 1'b0;
                drv_rand();
                chk("midrst_fetch_pc", bif.bpu_fetch_pc, 32'h0);
                chk("midrst_valid", 32'(bif.bpu_valid), 32'd0);
                chk("midrst_flush", 32'(bif.flush), 32'd0);
            end else begin
                drv_rand();
            end
            nxt();
        end
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
